// File: rtl/game_round_pkg.sv
// Shared types, default sizes and helpers for the game round/session controller.
package game_round_pkg;

  typedef enum logic [1:0] {
    ST_PLAY   = 2'd0,
    ST_RESULT = 2'd1,
    ST_OVER   = 2'd2
  } round_state_t;

  localparam int DEF_LIVES_INIT    = 3;
  localparam int DEF_LIVES_W       = 2;
  localparam int DEF_SCORE_W       = 8;
  localparam int DEF_LEVEL_W       = 2;
  localparam int DEF_LEVEL_UP_HITS = 4;

  function automatic logic [31:0] sat_inc(input logic [31:0] val, input logic [31:0] max_val);
    return (val >= max_val) ? max_val : val + 32'd1;
  endfunction

endpackage

// File: rtl/game_edge_detect.sv
// Single-bit rise/fall detector against a registered copy of the input.
module game_edge_detect (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_sig,
  output logic o_rise,
  output logic o_fall
);

  logic r_sig_q;
  logic r_live;

  // Edges are masked for the first cycle after reset so a level that was
  // already high when reset released is not mistaken for a fresh rise.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sig_q <= 1'b0;
      r_live  <= 1'b0;
    end else begin
      r_sig_q <= i_sig;
      r_live  <= 1'b1;
    end
  end

  assign o_rise = r_live & i_sig & ~r_sig_q;
  assign o_fall = r_live & ~i_sig & r_sig_q;

endmodule

// File: rtl/game_round_ctrl.sv
// Round/session controller between the launch key and the master game FSM:
// gates launches, commits round results and tracks score, lives and level.
//
// state  | meaning
// PLAY   | launch allowed (unless hold), waiting for end-of-round timer start
// RESULT | timer running, outcome latched, waiting for timer end to commit
// OVER   | lives exhausted, waiting for a fresh key press to restart
module game_round_ctrl
  import game_round_pkg::*;
#(
  parameter int LIVES_INIT    = DEF_LIVES_INIT,
  parameter int LIVES_W       = DEF_LIVES_W,
  parameter int SCORE_W       = DEF_SCORE_W,
  parameter int LEVEL_W       = DEF_LEVEL_W,
  parameter int LEVEL_UP_HITS = DEF_LEVEL_UP_HITS
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_launch_key,
  input  logic               i_game_won,
  input  logic               i_end_of_game_timer_running,
  output logic               o_fsm_launch_key,
  output logic [SCORE_W-1:0] o_score,
  output logic [SCORE_W-1:0] o_hi_score,
  output logic [LIVES_W-1:0] o_lives,
  output logic [LEVEL_W-1:0] o_level,
  output logic               o_game_over,
  output logic               o_result_valid,
  output logic               o_result_won
);

  localparam int          STREAK_W   = (LEVEL_UP_HITS < 2) ? 1 : $clog2(LEVEL_UP_HITS);
  localparam logic [31:0] SCORE_MAX  = (32'd1 << SCORE_W) - 32'd1;
  localparam logic [31:0] LEVEL_MAX  = (32'd1 << LEVEL_W) - 32'd1;
  localparam logic [STREAK_W-1:0] STREAK_LAST = STREAK_W'(LEVEL_UP_HITS - 1);

  round_state_t        r_state;
  logic [SCORE_W-1:0]  r_score;
  logic [SCORE_W-1:0]  r_hi_score;
  logic [LIVES_W-1:0]  r_lives;
  logic [LEVEL_W-1:0]  r_level;
  logic [STREAK_W-1:0] r_streak;
  logic                r_hold;
  logic                r_game_over;
  logic                r_result_valid;
  logic                r_result_won;
  logic                r_won_latch;

  logic w_t_rise;
  logic w_t_fall;
  logic w_k_rise;
  logic w_k_fall;

  game_edge_detect u_timer_edge (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_sig  (i_end_of_game_timer_running),
    .o_rise (w_t_rise),
    .o_fall (w_t_fall)
  );

  game_edge_detect u_key_edge (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_sig  (i_launch_key),
    .o_rise (w_k_rise),
    .o_fall (w_k_fall)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state        <= ST_PLAY;
      r_score        <= '0;
      r_hi_score     <= '0;
      r_lives        <= LIVES_W'(LIVES_INIT);
      r_level        <= '0;
      r_streak       <= '0;
      r_hold         <= 1'b0;
      r_game_over    <= 1'b0;
      r_result_valid <= 1'b0;
      r_result_won   <= 1'b0;
      r_won_latch    <= 1'b0;
    end else begin
      r_result_valid <= 1'b0;
      // hold is only ever set with the key high, so its release is the key fall
      if (w_k_fall) r_hold <= 1'b0;

      case (r_state)
        ST_PLAY: begin
          if (w_t_rise) begin
            r_won_latch <= i_game_won;
            r_state     <= ST_RESULT;
          end
        end

        ST_RESULT: begin
          if (w_t_fall) begin
            r_result_valid <= 1'b1;
            r_result_won   <= r_won_latch;
            if (r_won_latch) begin
              r_score <= SCORE_W'(sat_inc(32'(r_score), SCORE_MAX));
              if (r_streak == STREAK_LAST) begin
                r_streak <= '0;
                r_level  <= LEVEL_W'(sat_inc(32'(r_level), LEVEL_MAX));
              end else begin
                r_streak <= r_streak + STREAK_W'(1);
              end
              r_state <= ST_PLAY;
            end else begin
              r_streak <= '0;
              r_lives  <= r_lives - LIVES_W'(1);
              if (r_lives == LIVES_W'(1)) begin
                r_state     <= ST_OVER;
                r_game_over <= 1'b1;
                if (r_score > r_hi_score) r_hi_score <= r_score;
              end else begin
                r_state <= ST_PLAY;
              end
            end
          end
        end

        ST_OVER: begin
          if (w_k_rise) begin
            r_score     <= '0;
            r_lives     <= LIVES_W'(LIVES_INIT);
            r_level     <= '0;
            r_streak    <= '0;
            r_hold      <= 1'b1;
            r_game_over <= 1'b0;
            r_state     <= ST_PLAY;
          end
        end

        default: r_state <= ST_PLAY;
      endcase
    end
  end

  assign o_fsm_launch_key = i_launch_key & (r_state == ST_PLAY) & ~r_hold;
  assign o_score          = r_score;
  assign o_hi_score       = r_hi_score;
  assign o_lives          = r_lives;
  assign o_level          = r_level;
  assign o_game_over      = r_game_over;
  assign o_result_valid   = r_result_valid;
  assign o_result_won     = r_result_won;

endmodule

// File: tb/tb_game_round_ctrl.sv
// Directed bench for game_round_ctrl: default instance plus a 2-bit-score instance.
module tb_game_round_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic key1 = 1'b0, won1 = 1'b0, tmr1 = 1'b0;
  logic key2 = 1'b0, won2 = 1'b0, tmr2 = 1'b0;

  logic       f1, go1, rv1, rw1;
  logic [7:0] score1, hi1;
  logic [1:0] lives1, level1;

  logic       f2, go2, rv2, rw2;
  logic [1:0] score2, hi2;
  logic [1:0] lives2, level2;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  game_round_ctrl u_dut (
    .i_clk                       (clk),
    .i_rst                       (rst),
    .i_launch_key                (key1),
    .i_game_won                  (won1),
    .i_end_of_game_timer_running (tmr1),
    .o_fsm_launch_key            (f1),
    .o_score                     (score1),
    .o_hi_score                  (hi1),
    .o_lives                     (lives1),
    .o_level                     (level1),
    .o_game_over                 (go1),
    .o_result_valid              (rv1),
    .o_result_won                (rw1)
  );

  game_round_ctrl #(.SCORE_W(2)) u_dut2 (
    .i_clk                       (clk),
    .i_rst                       (rst),
    .i_launch_key                (key2),
    .i_game_won                  (won2),
    .i_end_of_game_timer_running (tmr2),
    .o_fsm_launch_key            (f2),
    .o_score                     (score2),
    .o_hi_score                  (hi2),
    .o_lives                     (lives2),
    .o_level                     (level2),
    .o_game_over                 (go2),
    .o_result_valid              (rv2),
    .o_result_won                (rw2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input int exp);
    n_checks++;
    assert (obs === 32'(exp)) else begin
      n_errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // 10-cycle timer pulse; checks the one-cycle commit pulse and outcome
  task automatic round(input int sel, input logic w, input string tag);
    if (sel == 1) begin won1 = w; tmr1 = 1'b1; end
    else          begin won2 = w; tmr2 = 1'b1; end
    step(10);
    if (sel == 1) tmr1 = 1'b0; else tmr2 = 1'b0;
    step(1);
    chk({tag, "_rv"}, (sel == 1) ? 32'(rv1) : 32'(rv2), 1);
    chk({tag, "_rw"}, (sel == 1) ? 32'(rw1) : 32'(rw2), int'(w));
    step(1);
    chk({tag, "_rv_off"}, (sel == 1) ? 32'(rv1) : 32'(rv2), 0);
  endtask

  task automatic restart(input int sel);
    if (sel == 1) key1 = 1'b0; else key2 = 1'b0;
    step(1);
    if (sel == 1) key1 = 1'b1; else key2 = 1'b1;
    step(1);
    if (sel == 1) key1 = 1'b0; else key2 = 1'b0;
    step(1);
  endtask

  initial begin
    // reset with the timer already running: its later fall must be ignored
    rst  = 1'b1;
    tmr1 = 1'b1;
    step(2);
    rst = 1'b0;
    step(1);
    chk("rst_score", 32'(score1), 0);
    chk("rst_hi", 32'(hi1), 0);
    chk("rst_lives", 32'(lives1), 3);
    chk("rst_level", 32'(level1), 0);
    chk("rst_go", 32'(go1), 0);
    chk("rst_rv", 32'(rv1), 0);
    chk("rst_rw", 32'(rw1), 0);
    tmr1 = 1'b0;
    step(1);
    chk("stale_fall_rv", 32'(rv1), 0);
    step(1);
    chk("stale_fall_rv2", 32'(rv1), 0);
    key1 = 1'b1;
    #1;
    chk("play_launch", 32'(f1), 1);
    key1 = 1'b0;
    step(1);

    // three wins
    round(1, 1'b1, "w1"); chk("w1_score", 32'(score1), 1);
    round(1, 1'b1, "w2"); chk("w2_score", 32'(score1), 2);
    round(1, 1'b1, "w3"); chk("w3_score", 32'(score1), 3);
    chk("w3_lives", 32'(lives1), 3);
    chk("w3_level", 32'(level1), 0);

    // fourth win levels up
    round(1, 1'b1, "w4");
    chk("w4_score", 32'(score1), 4);
    chk("w4_level", 32'(level1), 1);

    // two wins, a loss (streak cleared), then 4 wins for the next level
    round(1, 1'b1, "w5");
    round(1, 1'b1, "w6");
    chk("w6_level", 32'(level1), 1);
    key1 = 1'b1;
    won1 = 1'b0;
    tmr1 = 1'b1;
    step(2);
    chk("result_block", 32'(f1), 0);
    key1 = 1'b0;
    tmr1 = 1'b0;
    step(2);
    chk("l1_lives", 32'(lives1), 2);
    chk("l1_score", 32'(score1), 6);
    chk("l1_rw", 32'(rw1), 0);
    round(1, 1'b1, "w7");
    round(1, 1'b1, "w8");
    round(1, 1'b1, "w9");
    chk("w9_level", 32'(level1), 1);
    round(1, 1'b1, "w10");
    chk("w10_level", 32'(level1), 2);
    chk("w10_score", 32'(score1), 10);
    for (int i = 0; i < 4; i++) round(1, 1'b1, "w11_14");
    chk("w14_level", 32'(level1), 3);
    for (int i = 0; i < 4; i++) round(1, 1'b1, "w15_18");
    chk("w18_level_sat", 32'(level1), 3);
    chk("w18_score", 32'(score1), 18);

    // lose remaining lives; key held through the final commit
    round(1, 1'b0, "l2");
    chk("l2_lives", 32'(lives1), 1);
    chk("l2_go", 32'(go1), 0);
    key1 = 1'b1;
    round(1, 1'b0, "l3");
    chk("l3_lives", 32'(lives1), 0);
    chk("l3_go", 32'(go1), 1);
    chk("l3_hi", 32'(hi1), 18);
    chk("over_launch", 32'(f1), 0);
    step(3);
    chk("over_held_go", 32'(go1), 1);
    key1 = 1'b0;
    step(1);
    chk("over_rel_go", 32'(go1), 1);

    // fresh press restarts; held key must not launch until released
    key1 = 1'b1;
    step(1);
    chk("rs_go", 32'(go1), 0);
    chk("rs_score", 32'(score1), 0);
    chk("rs_lives", 32'(lives1), 3);
    chk("rs_level", 32'(level1), 0);
    chk("rs_hi", 32'(hi1), 18);
    chk("rs_hold", 32'(f1), 0);
    step(4);
    chk("rs_hold_long", 32'(f1), 0);
    key1 = 1'b0;
    step(1);
    chk("rs_released", 32'(f1), 0);
    key1 = 1'b1;
    #1;
    chk("rs_new_press", 32'(f1), 1);
    key1 = 1'b0;
    step(1);

    // a scoreless session keeps the old high score
    round(1, 1'b0, "s2l1"); chk("s2l1_lives", 32'(lives1), 2);
    round(1, 1'b0, "s2l2"); chk("s2l2_lives", 32'(lives1), 1);
    round(1, 1'b0, "s2l3"); chk("s2l3_lives", 32'(lives1), 0);
    chk("s2_go", 32'(go1), 1);
    chk("s2_hi", 32'(hi1), 18);

    // reset in the middle of a round
    restart(1);
    round(1, 1'b1, "s3w1");
    chk("s3w1_score", 32'(score1), 1);
    won1 = 1'b1;
    tmr1 = 1'b1;
    step(3);
    rst = 1'b1;
    step(1);
    chk("mid_rst_score", 32'(score1), 0);
    chk("mid_rst_hi", 32'(hi1), 0);
    chk("mid_rst_lives", 32'(lives1), 3);
    chk("mid_rst_level", 32'(level1), 0);
    chk("mid_rst_go", 32'(go1), 0);
    chk("mid_rst_rv", 32'(rv1), 0);
    chk("mid_rst_rw", 32'(rw1), 0);
    rst = 1'b0;
    step(2);
    tmr1 = 1'b0;
    step(1);
    chk("mid_rst_fall_rv", 32'(rv1), 0);
    step(1);
    chk("mid_rst_fall_rv2", 32'(rv1), 0);
    chk("mid_rst_fall_score", 32'(score1), 0);
    won1 = 1'b0;

    // 2-bit score instance: saturation and high-score retention
    round(2, 1'b1, "n1");
    round(2, 1'b1, "n2");
    round(2, 1'b1, "n3");
    chk("n3_score", 32'(score2), 3);
    round(2, 1'b1, "n4");
    round(2, 1'b1, "n5");
    chk("n5_score_sat", 32'(score2), 3);
    chk("n5_level", 32'(level2), 1);
    for (int i = 0; i < 3; i++) round(2, 1'b0, "nl");
    chk("n_go", 32'(go2), 1);
    chk("n_hi", 32'(hi2), 3);
    restart(2);
    chk("n_rs_score", 32'(score2), 0);
    round(2, 1'b1, "m1");
    chk("m1_score", 32'(score2), 1);
    for (int i = 0; i < 3; i++) round(2, 1'b0, "ml");
    chk("m_go", 32'(go2), 1);
    chk("m_hi_kept", 32'(hi2), 3);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
